sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14: sprite ROM word-address width.
REQ-002 Parameter DATA_W, default 16: sprite ROM data width.
REQ-003 Parameter BURST_LEN, default 8: words fetched per granted request (one sprite row); range 2..16.
REQ-004 Parameter ROM_LAT, default 1: ROM read latency in cycles, rom_en to rom_data; range 1..3.
REQ-005 Port clock  in  1: single clock; all state updates on its rising edge.
REQ-006 Port reset  in  1: synchronous, active-high reset.
REQ-007 Ports p1_req / p2_req  in  1: fetch request; held high by requester until its ack.
REQ-008 Ports p1_addr / p2_addr  in  ADDR_W: burst base address; stable while req is high.
REQ-009 Ports p1_ack / p2_ack  out  1: one-cycle pulse; request accepted and base address captured.
REQ-010 Ports p1_valid / p2_valid  out  1: returned word is valid for that requester this cycle.
REQ-011 Ports p1_last / p2_last  out  1: high with the final (BURST_LEN-th) valid word of a burst.
REQ-012 Ports p1_data / p2_data  out  DATA_W: rom_data when own valid is high, else 0.
REQ-013 Port rom_en  out  1: ROM read strobe.
REQ-014 Port rom_addr  out  ADDR_W: ROM read address; 0 when rom_en low.
REQ-015 Port rom_data  in  DATA_W: ROM read data, valid ROM_LAT cycles after rom_en.

Function
REQ-016 FSM states: IDLE, BURST, DRAIN; exactly one active.
REQ-017 IDLE: req sampled; if any req high, next cycle = BURST with captured base, owner, ack pulse to owner; else stay IDLE.
REQ-018 Arbitration round-robin: single req -> that requester; both -> requester not granted last; last-grant register resets to p2 so p1 wins first tie.
REQ-019 BURST lasts exactly BURST_LEN cycles; cycle k (0-based): rom_en=1, rom_addr=base+k modulo 2^ADDR_W; ack only in k=0.
REQ-020 After BURST: DRAIN for exactly ROM_LAT cycles, rom_en=0, then IDLE.
REQ-021 Request at IDLE cycle t -> ack and first rom_en at t+1; first valid at t+1+ROM_LAT; last at t+BURST_LEN+ROM_LAT; IDLE again at t+BURST_LEN+ROM_LAT+1.
REQ-022 Owner and last flags travel a ROM_LAT-deep tag pipeline in lockstep with rom_en so valid/last align with rom_data.
REQ-023 Never both p1_valid and p2_valid high; non-owner valid, last, data stay 0.
REQ-024 req changes during BURST/DRAIN ignored; req dropped before IDLE sampling -> no transaction, no ack.
REQ-025 Continuously held req with other idle -> re-granted each IDLE; gap between bursts' first rom_en = BURST_LEN+ROM_LAT+1 cycles.
REQ-026 Address wrap-around silent; no error flag.

Reset
REQ-027 Reset high at an edge: state IDLE, tag pipeline cleared, last-grant = p2, base/owner cleared.
REQ-028 All outputs 0 the cycle after reset asserts; reset mid-BURST/DRAIN aborts burst, no further valid/last for it.
REQ-029 Requests pending during reset are not acked; first IDLE sample after reset deasserts treats them as new.

Structure
REQ-030 Shared package sprite_pkg holds ADDR_W/DATA_W defaults, BURST_LEN, ROM_LAT, FSM state encoding, owner encoding (OWNER_P1=0, OWNER_P2=1).
REQ-031 One sub-module, sprite_tag_pipe: ROM_LAT-stage shift register of {valid, owner, last}, synchronous reset to 0.

Verification (ROM model: rom_data = rom_addr, zero-extended; BURST_LEN=8, ROM_LAT=1)
REQ-032 p1_req, p1_addr=0x0100 alone -> p1_ack 1 cycle later; rom_addr 0x0100..0x0107 on 8 consecutive cycles; p1_data 0x0100..0x0107 with p1_valid; p1_last on 0x0107; p2 outputs 0.
REQ-033 p1_req and p2_req high same cycle after reset -> p1 burst first, p2 acked 10 cycles after p1_ack; repeat tie -> p1 served first again (last grant p2).
REQ-034 p2_addr=0x3FFC -> rom_addr 0x3FFC,0x3FFD,0x3FFE,0x3FFF,0x0000..0x0003; p2_last on 0x0003.
REQ-035 Reset asserted on p1's 3rd valid word -> all outputs 0 next cycle, no more p1_valid; new p1_req after release served with normal timing.
REQ-036 p1_req held continuously, p2 idle -> p1_ack every 10 cycles; p2_req raised mid-burst -> p2 acked at next IDLE before p1.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the two-port sprite ROM arbiter.
package sprite_pkg;

  localparam int ADDR_W_DEF    = 14;
  localparam int DATA_W_DEF    = 16;
  localparam int BURST_LEN_DEF = 8;
  localparam int ROM_LAT_DEF   = 1;
  // Wide enough for the largest supported burst (16) and drain (3) counts.
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic OWNER_P1 = 1'b0;
  localparam logic OWNER_P2 = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
    logic last;
  } tag_t;

endpackage

// File: rtl/sprite_tag_pipe.sv
// Delay line carrying {valid, owner, last} alongside the ROM read latency,
// so each returned word arrives tagged with its requester.
module sprite_tag_pipe
  import sprite_pkg::*;
#(
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic clock_i,
  input  logic reset_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  generate
    for (genvar gi = 0; gi < ROM_LAT; gi++) begin : g_stage
      tag_t stage_q;
      if (gi == 0) begin : g_head
        always_ff @(posedge clock_i) begin
          if (reset_i) stage_q <= '0;
          else         stage_q <= tag_i;
        end
      end else begin : g_body
        always_ff @(posedge clock_i) begin
          if (reset_i) stage_q <= '0;
          else         stage_q <= g_stage[gi-1].stage_q;
        end
      end
    end
  endgenerate

  assign tag_o = g_stage[ROM_LAT-1].stage_q;

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter letting two sprite fetchers share one ROM port,
// issuing fixed-length address bursts and steering returned words back.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int ROM_LAT   = ROM_LAT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p1_req,
  input  logic              p2_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [ADDR_W-1:0] p2_addr,
  output logic              p1_ack,
  output logic              p2_ack,
  output logic              p1_valid,
  output logic              p2_valid,
  output logic              p1_last,
  output logic              p2_last,
  output logic [DATA_W-1:0] p1_data,
  output logic [DATA_W-1:0] p2_data,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic               grant_p1;
  tag_t               tag_in, tag_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      owner_q      <= OWNER_P1;
      last_grant_q <= OWNER_P2;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    // On a tie, p1 wins only if p2 was the most recent grant.
    grant_p1     = p1_req && (!p2_req || (last_grant_q == OWNER_P2));
    case (state_q)
      ST_IDLE: begin
        if (p1_req || p2_req) begin
          owner_d      = grant_p1 ? OWNER_P1 : OWNER_P2;
          base_d       = grant_p1 ? p1_addr : p2_addr;
          last_grant_d = grant_p1 ? OWNER_P1 : OWNER_P2;
          cnt_d        = '0;
          state_d      = ST_BURST;
        end
      end
      ST_BURST: begin
        if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(ROM_LAT - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rom_en   = (state_q == ST_BURST);
  assign rom_addr = rom_en ? (base_q + ADDR_W'(cnt_q)) : '0;
  assign p1_ack   = rom_en && (cnt_q == '0) && (owner_q == OWNER_P1);
  assign p2_ack   = rom_en && (cnt_q == '0) && (owner_q == OWNER_P2);

  assign tag_in.valid = rom_en;
  assign tag_in.owner = owner_q;
  assign tag_in.last  = rom_en && (cnt_q == CNT_W'(BURST_LEN - 1));

  sprite_tag_pipe #(
    .ROM_LAT (ROM_LAT)
  ) u_tag_pipe (
    .clock_i (clock),
    .reset_i (reset),
    .tag_i   (tag_in),
    .tag_o   (tag_out)
  );

  assign p1_valid = tag_out.valid && (tag_out.owner == OWNER_P1);
  assign p2_valid = tag_out.valid && (tag_out.owner == OWNER_P2);
  assign p1_last  = p1_valid && tag_out.last;
  assign p2_last  = p2_valid && tag_out.last;
  assign p1_data  = p1_valid ? rom_data : '0;
  assign p2_data  = p2_valid ? rom_data : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: table of request scenarios plus hand-written
// reset/hold sequences, with a scoreboard of expected ROM addresses and words.
module tb_sprite_rom_arbiter;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int BL = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          p1_req, p2_req;
  logic [AW-1:0] p1_addr, p2_addr;
  logic          p1_ack, p2_ack, p1_valid, p2_valid, p1_last, p2_last;
  logic [DW-1:0] p1_data, p2_data;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  sprite_rom_arbiter #(
    .ADDR_W (AW), .DATA_W (DW), .BURST_LEN (BL), .ROM_LAT (1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .p1_req   (p1_req),
    .p2_req   (p2_req),
    .p1_addr  (p1_addr),
    .p2_addr  (p2_addr),
    .p1_ack   (p1_ack),
    .p2_ack   (p2_ack),
    .p1_valid (p1_valid),
    .p2_valid (p2_valid),
    .p1_last  (p1_last),
    .p2_last  (p2_last),
    .p1_data  (p1_data),
    .p2_data  (p2_data),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clock = ~clock;

  // ROM model: one-cycle latency, data equals zero-extended address.
  always @(posedge clock) rom_data <= {{(DW-AW){1'b0}}, rom_addr};

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          data_q[$];
  logic [AW-1:0] addr_q[$];
  int            checks = 0;
  int            failures = 0;
  int            ack2_cnt = 0;
  bit            mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_burst(input logic owner, input logic [AW-1:0] base);
    logic [AW-1:0] a;
    for (int k = 0; k < BL; k++) begin
      a = base + AW'(k);
      addr_q.push_back(a);
      data_q.push_back('{owner: owner, data: {{(DW-AW){1'b0}}, a}, last: (k == BL - 1)});
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (mon_en) begin
      exp_t e;
      logic [AW-1:0] ea;
      chk("ack_exclusive", {31'b0, p1_ack && p2_ack}, 32'd0);
      chk("valid_exclusive", {31'b0, p1_valid && p2_valid}, 32'd0);
      if (p2_ack) ack2_cnt++;
      if (rom_en) begin
        if (addr_q.size() == 0) begin
          chk("unexpected_rom_en", {31'b0, rom_en}, 32'd0);
        end else begin
          ea = addr_q.pop_front();
          chk("rom_addr", {18'b0, rom_addr}, {18'b0, ea});
        end
      end else begin
        chk("rom_addr_idle", {18'b0, rom_addr}, 32'd0);
      end
      if (p1_valid || p2_valid) begin
        if (data_q.size() == 0) begin
          chk("unexpected_valid", {30'b0, p1_valid, p2_valid}, 32'd0);
        end else begin
          e = data_q.pop_front();
          chk("valid_owner", {31'b0, p2_valid}, {31'b0, e.owner});
          chk("data", {16'b0, p2_valid ? p2_data : p1_data}, {16'b0, e.data});
          chk("last", {31'b0, p2_valid ? p2_last : p1_last}, {31'b0, e.last});
        end
      end
      if (!p1_valid) chk("p1_idle_out", {15'b0, p1_last, p1_data}, 32'd0);
      if (!p2_valid) chk("p2_idle_out", {15'b0, p2_last, p2_data}, 32'd0);
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_ack(output int who, output int at);
    who = -1;
    at  = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (p1_ack || p2_ack) begin
        who = p2_ack ? 1 : 0;
        at  = cyc;
        break;
      end
    end
    if (who < 0) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout at cycle %0d: got no ack expected ack within 30 cycles", cyc);
    end
  endtask

  task automatic drain_and_check();
    repeat (12) step();
    chk("queue_empty", data_q.size() + addr_q.size(), 32'd0);
  endtask

  typedef struct {
    bit            r1;
    bit            r2;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    int            first;   // 0 = p1 granted first, 1 = p2
  } vec_t;

  vec_t vecs[8];

  initial begin
    int who, who2, at, at2, a_prev, c0, n2;

    vecs[0] = '{1, 0, 14'h0100, 14'h0000, 0};
    vecs[1] = '{0, 1, 14'h0000, 14'h3FFC, 1};  // wraps past top of ROM
    vecs[2] = '{1, 1, 14'h0200, 14'h0300, 0};  // first tie after reset: p1
    vecs[3] = '{1, 1, 14'h0210, 14'h0310, 0};  // last grant p2 again: p1
    vecs[4] = '{0, 1, 14'h0010, 14'h0020, 1};
    vecs[5] = '{1, 1, 14'h0220, 14'h0320, 0};
    vecs[6] = '{1, 0, 14'h0400, 14'h0000, 0};
    vecs[7] = '{1, 1, 14'h0500, 14'h0600, 1};  // last grant p1: p2 wins tie

    reset = 1'b1;
    p1_req = 1'b0; p2_req = 1'b0;
    p1_addr = '0;  p2_addr = '0;
    repeat (2) @(posedge clock);
    step();
    mon_en = 1;
    chk("reset_flags", {25'b0, p1_ack, p2_ack, p1_valid, p2_valid, p1_last, p2_last, rom_en}, 32'd0);
    chk("reset_data", {p1_data, p2_data}, 32'd0);
    reset = 1'b0;
    step();

    for (int v = 0; v < 8; v++) begin
      step();
      p1_req = vecs[v].r1; p1_addr = vecs[v].a1;
      p2_req = vecs[v].r2; p2_addr = vecs[v].a2;
      c0 = cyc;
      if (vecs[v].first == 0) begin
        if (vecs[v].r1) push_burst(1'b0, vecs[v].a1);
        if (vecs[v].r2) push_burst(1'b1, vecs[v].a2);
      end else begin
        if (vecs[v].r2) push_burst(1'b1, vecs[v].a2);
        if (vecs[v].r1) push_burst(1'b0, vecs[v].a1);
      end
      wait_ack(who, at);
      chk("first_ack_owner", who, vecs[v].first);
      chk("ack_latency", at - c0, 32'd1);
      if (who == 0) p1_req = 1'b0; else p2_req = 1'b0;
      if (vecs[v].r1 && vecs[v].r2) begin
        wait_ack(who2, at2);
        chk("second_ack_owner", who2, 1 - vecs[v].first);
        chk("ack_gap", at2 - at, 32'd10);
        p1_req = 1'b0; p2_req = 1'b0;
      end
      drain_and_check();
      $display("vector %0d: r1=%0d r2=%0d first_owner=%0d ack_cycle=%0d", v, vecs[v].r1, vecs[v].r2, who, at);
    end

    // p1 holds its request; p2 arrives mid-burst and takes the next slot.
    step();
    p1_req = 1'b1; p1_addr = 14'h0800;
    c0 = cyc;
    push_burst(1'b0, 14'h0800);
    wait_ack(who, at);
    chk("hold_ack1_owner", who, 32'd0);
    chk("hold_ack1_latency", at - c0, 32'd1);
    push_burst(1'b0, 14'h0800);
    a_prev = at;
    wait_ack(who, at);
    chk("hold_ack2_owner", who, 32'd0);
    chk("hold_ack2_gap", at - a_prev, 32'd10);
    repeat (3) step();
    p2_req = 1'b1; p2_addr = 14'h0900;
    push_burst(1'b1, 14'h0900);
    push_burst(1'b0, 14'h0800);
    a_prev = at;
    wait_ack(who, at);
    chk("hold_ack3_owner", who, 32'd1);
    chk("hold_ack3_gap", at - a_prev, 32'd10);
    p2_req = 1'b0;
    a_prev = at;
    wait_ack(who, at);
    chk("hold_ack4_owner", who, 32'd0);
    chk("hold_ack4_gap", at - a_prev, 32'd10);
    p1_req = 1'b0;
    drain_and_check();
    $display("hold sequence: p2 slotted between p1 bursts, final ack cycle=%0d", at);

    // Reset on p1's third returned word aborts the burst.
    step();
    p1_req = 1'b1; p1_addr = 14'h0100;
    c0 = cyc;
    push_burst(1'b0, 14'h0100);
    wait_ack(who, at);
    chk("abort_ack_latency", at - c0, 32'd1);
    repeat (3) step();
    chk("abort_third_valid", {31'b0, p1_valid}, 32'd1);
    reset = 1'b1;
    data_q.delete();
    addr_q.delete();
    step();
    chk("abort_flags", {25'b0, p1_ack, p2_ack, p1_valid, p2_valid, p1_last, p2_last, rom_en}, 32'd0);
    chk("abort_data", {p1_data, p2_data}, 32'd0);
    step();
    chk("abort_no_ack_in_reset", {31'b0, p1_ack}, 32'd0);
    reset = 1'b0;
    c0 = cyc;
    push_burst(1'b0, 14'h0100);
    wait_ack(who, at);
    chk("post_reset_owner", who, 32'd0);
    chk("post_reset_latency", at - c0, 32'd1);
    p1_req = 1'b0;
    drain_and_check();
    $display("reset abort: pending p1 re-served at cycle %0d", at);

    // A p2 request dropped before the idle sample is never acked.
    step();
    p1_req = 1'b1; p1_addr = 14'h0A00;
    push_burst(1'b0, 14'h0A00);
    wait_ack(who, at);
    p1_req = 1'b0;
    n2 = ack2_cnt;
    step();
    p2_req = 1'b1; p2_addr = 14'h0B00;
    repeat (2) step();
    p2_req = 1'b0;
    drain_and_check();
    chk("dropped_req_no_ack", ack2_cnt - n2, 32'd0);
    $display("dropped request: p2 acks seen=%0d", ack2_cnt - n2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
